key_event_encoder: RTL and testbench

KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

---
 rtl/keypad_pkg.sv | 14 +
 rtl/key_debounce.sv | 41 ++++
 rtl/key_event_encoder.sv | 133 +++++++++++++
 tb/tb_key_event_encoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and event record for the keypad event encoder.
package keypad_pkg;

    localparam int EVT_FIFO_DEPTH = 4;
    localparam int DEF_NUM_KEYS   = 13;
    localparam int DEF_DB_CYCLES  = 1000;
    localparam int DEF_CODE_W     = $clog2(DEF_NUM_KEYS + 1);

    typedef struct packed {
        logic                  release_flag;
        logic [DEF_CODE_W-1:0] code;
    } key_evt_t;

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser followed by a stable-count debouncer.
module key_debounce #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic debounced
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // Synchronise the raw level, then flip only after DB_CYCLES consecutive mismatches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            debounced <= 1'b0;
            count     <= {CNT_W{1'b0}};
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != debounced) begin
                if (count == CNT_MAX) begin
                    debounced <= ~debounced;
                    count     <= {CNT_W{1'b0}};
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else begin
                count <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// Debounced lowest-key encoder with press/release events.
// Define KEY_EVENT_FIFO_EN to buffer events in a small FIFO; otherwise events stream straight out.
module key_event_encoder
    import keypad_pkg::*;
#(
    parameter  int NUM_KEYS  = DEF_NUM_KEYS,
    parameter  int DB_CYCLES = DEF_DB_CYCLES,
    localparam int CODE_W    = $clog2(NUM_KEYS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              press_evt,
    output logic              release_evt,
    output logic              evt_valid,
    output logic [CODE_W:0]   evt_data,
    input  logic              evt_ready,
    output logic              evt_overflow
);

    localparam logic [CODE_W-1:0] KEY_NONE = {CODE_W{1'b1}};

    logic [NUM_KEYS-1:0] deb;
    logic [CODE_W-1:0]   enc;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .raw      (keys[k]),
            .debounced(deb[k])
        );
    end

    function automatic logic [CODE_W-1:0] encode_lowest(input logic [NUM_KEYS-1:0] bits);
        logic [CODE_W-1:0] result;
        result = KEY_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (bits[i]) begin
                result = CODE_W'(i);
            end
        end
        return result;
    endfunction

    // Priority-encode the debounced key vector.
    always_comb begin
        enc = encode_lowest(deb);
    end

    // Latch a new code and raise exactly one event pulse when it changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code    <= KEY_NONE;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else if (enc != key_code) begin
            key_code    <= enc;
            press_evt   <= (enc != KEY_NONE);
            release_evt <= (enc == KEY_NONE);
        end else begin
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end
    end

    assign key_valid = (key_code != KEY_NONE);

`ifdef KEY_EVENT_FIFO_EN
    localparam int PTR_W = $clog2(EVT_FIFO_DEPTH);

    logic [CODE_W:0]  fifo_mem [EVT_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   fill;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;

    assign push      = press_evt | release_evt;
    assign evt_valid = (fill != {(PTR_W + 1){1'b0}});
    assign full      = (fill == (PTR_W + 1)'(EVT_FIFO_DEPTH));
    assign pop       = evt_valid & evt_ready;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign accept    = push & (~full | pop);
    assign evt_data  = fifo_mem[rd_ptr];

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= {PTR_W{1'b0}};
            wr_ptr       <= {PTR_W{1'b0}};
            fill         <= {(PTR_W + 1){1'b0}};
            evt_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push && !accept) begin
                evt_overflow <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   fill <= fill + (PTR_W + 1)'(1);
                2'b01:   fill <= fill - (PTR_W + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Event storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= {release_evt, key_code};
        end
    end
`else
    logic unused_evt_ready;

    assign unused_evt_ready = evt_ready;
    assign evt_valid        = press_evt | release_evt;
    assign evt_data         = {release_evt, key_code};
    assign evt_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder (NUM_KEYS=13, DB_CYCLES=4); FIFO checks need KEY_EVENT_FIFO_EN.
module tb_key_event_encoder;
    import keypad_pkg::*;

    localparam int NK = 13;
    localparam int DB = 4;
    localparam int CW = 4;
    localparam logic [CW-1:0] NONE = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys;
    logic          evt_ready;
    logic [CW-1:0] key_code;
    logic          key_valid;
    logic          press_evt;
    logic          release_evt;
    logic          evt_valid;
    logic [CW:0]   evt_data;
    logic          evt_overflow;

    always #5 clk = ~clk;

    key_event_encoder #(.NUM_KEYS(NK), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .keys(keys), .key_code(key_code), .key_valid(key_valid),
        .press_evt(press_evt), .release_evt(release_evt), .evt_valid(evt_valid),
        .evt_data(evt_data), .evt_ready(evt_ready), .evt_overflow(evt_overflow)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a key's accepted level flips once its synchronised
    // level (raw two samples late) has disagreed for DB edges in a row;
    // the reported code is the lowest accepted key, one edge later.
    logic [NK-1:0] m_s1, m_s2, m_deb;
    int            m_run [NK];
    logic [CW-1:0] m_code;
    logic          m_press, m_rel, m_ovf;
    key_evt_t      m_q [$];

    function automatic logic [CW-1:0] lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) begin
            if (v[i]) return 4'(i);
        end
        return NONE;
    endfunction

    always @(posedge clk) begin
        logic [CW-1:0] e;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
            m_code = NONE; m_press = 1'b0; m_rel = 1'b0; m_ovf = 1'b0;
            m_q.delete();
        end else begin
`ifdef KEY_EVENT_FIFO_EN
            if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
            if (m_press || m_rel) begin
                if (m_q.size() < EVT_FIFO_DEPTH) m_q.push_back('{release_flag: m_rel, code: m_code});
                else m_ovf = 1'b1;
            end
`endif
            e = lowest(m_deb);
            m_press = (e != m_code) && (e != NONE);
            m_rel   = (e != m_code) && (e == NONE);
            m_code  = e;
            for (int k = 0; k < NK; k++) begin
                if (m_s2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_deb[k] = ~m_deb[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = keys;
        end
    end

    task automatic compare_all();
        check_val("key_code", key_code, m_code);
        check_val("key_valid", key_valid, m_code != NONE);
        check_val("press_evt", press_evt, m_press);
        check_val("release_evt", release_evt, m_rel);
        check_val("evt_excl", press_evt & release_evt, 1'b0);
`ifdef KEY_EVENT_FIFO_EN
        check_val("evt_valid", evt_valid, m_q.size() != 0);
        if (m_q.size() != 0) check_val("evt_data", evt_data, m_q[0]);
        check_val("evt_overflow", evt_overflow, m_ovf);
`else
        check_val("evt_valid", evt_valid, m_press | m_rel);
        check_val("evt_data", evt_data, {m_rel, m_code});
        check_val("evt_overflow", evt_overflow, 1'b0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Hold the current keys and expect the new code (and pulse) exactly DB+3 edges later.
    task automatic settle(input logic [CW-1:0] code, input logic pr, input logic rl, input string tag);
        repeat (DB + 2) tick();
        tick();
        check_val({tag, "_code"}, key_code, code);
        check_val({tag, "_press"}, press_evt, pr);
        check_val({tag, "_rel"}, release_evt, rl);
        tick();
        check_val({tag, "_pulse"}, press_evt | release_evt, 1'b0);
    endtask

`ifdef KEY_EVENT_FIFO_EN
    task automatic drain(input logic [CW:0] e0, input logic [CW:0] e1,
                         input logic [CW:0] e2, input logic [CW:0] e3, input string tag);
        logic [CW:0] exp_a [4];
        exp_a = '{e0, e1, e2, e3};
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val({tag, "_valid"}, evt_valid, 1'b1);
            check_val({tag, "_data"}, evt_data, exp_a[i]);
            tick();
        end
        check_val({tag, "_empty"}, evt_valid, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1; keys = '0; evt_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_code", key_code, NONE);
        check_val("rst_valid", evt_valid, 1'b0);
        rst = 1'b0;

        // Single key: code 4 appears exactly 7 edges after the raw change.
        keys = 13'h0010;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val("s1_code", key_code, (i >= 7) ? 4'd4 : NONE);
            check_val("s1_press", press_evt, i == 7);
        end
        keys = '0;
        settle(NONE, 1'b0, 1'b1, "s1_release");

        // A 3-cycle glitch must be filtered out.
        keys = 13'h0004;
        repeat (3) tick();
        keys = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("s2_code", key_code, NONE);
            check_val("s2_evt", press_evt | release_evt, 1'b0);
        end

        // Priority: 9, then 1 over 9, back to 9, then release.
        keys = 13'h0200;
        settle(4'd9, 1'b1, 1'b0, "s3_k9");
        keys = 13'h0202;
        settle(4'd1, 1'b1, 1'b0, "s3_k1");
        keys = 13'h0200;
        settle(4'd9, 1'b1, 1'b0, "s3_back9");
        keys = '0;
        settle(NONE, 1'b0, 1'b1, "s3_none");

        // Reset in the middle of a debounce.
        keys = 13'h0008;
        settle(4'd3, 1'b1, 1'b0, "s5_k3");
        keys = 13'h0009;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_val("s5_rst_code", key_code, NONE);
        check_val("s5_rst_valid", evt_valid, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_val("s5_code", key_code, (i == 7) ? 4'd0 : NONE);
        end

`ifdef KEY_EVENT_FIFO_EN
        // Fill past capacity with the consumer stalled.
        evt_ready = 1'b1;
        repeat (3) tick();
        evt_ready = 1'b0;
        keys = '0;      settle(NONE,  1'b0, 1'b1, "s4_e1");
        keys = 13'h0020; settle(4'd5, 1'b1, 1'b0, "s4_e2");
        keys = 13'h0040; settle(4'd6, 1'b1, 1'b0, "s4_e3");
        keys = '0;      settle(NONE,  1'b0, 1'b1, "s4_e4");
        check_val("s4_ovf_before", evt_overflow, 1'b0);
        keys = 13'h0080; settle(4'd7, 1'b1, 1'b0, "s4_e5");
        check_val("s4_ovf", evt_overflow, 1'b1);
        drain(5'h1F, 5'h05, 5'h06, 5'h1F, "s4_drain");

        // Push and pop together while full.
        evt_ready = 1'b0;
        keys = '0;      settle(NONE,  1'b0, 1'b1, "s4_f1");
        keys = 13'h0004; settle(4'd2, 1'b1, 1'b0, "s4_f2");
        keys = 13'h0008; settle(4'd3, 1'b1, 1'b0, "s4_f3");
        keys = '0;      settle(NONE,  1'b0, 1'b1, "s4_f4");
        keys = 13'h0010;
        repeat (DB + 3) tick();
        check_val("s4_pp_press", press_evt, 1'b1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        tick();
        drain(5'h02, 5'h03, 5'h1F, 5'h04, "s4_pp_drain");
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) keys = '0;
            else keys = 13'($urandom & $urandom);
            if ($urandom_range(0, 40) == 0) rst = 1'b1;
            repeat ($urandom_range(1, 12)) begin
                evt_ready = 1'($urandom_range(0, 1));
                tick();
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
